// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation scan controller.
// Holds the shift-direction encoding, the FSM state type and the search-range helper.
package me_pkg;

  // sel[0] selects up/down on the right-column mux; SEL_LEFT moves a new strip in.
  typedef enum logic [1:0] {
    SEL_DOWN = 2'b00,
    SEL_UP   = 2'b01,
    SEL_LEFT = 2'b10
  } sel_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CPR,
    FILL,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  function automatic int me_range(input int macro_dim, input int search_dim);
    return search_dim - macro_dim + 1;
  endfunction

endpackage

// File: rtl/me_delay_line.sv
// Fixed-depth register pipeline with synchronous clear.
// Lines up per-candidate tags with the SAD emerging from the datapath.
module me_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/me_scan_controller.sv
// Sequencer for the ME datapath: loads the macroblock, pre-fills and snake-scans the search window.
// Optional ME_ABORT_EN adds an abort_i input that returns any active search to IDLE without done.
//
// state    | meaning
// IDLE     | waiting for start_i
// LOAD_CPR | shift macroblock rows into CPR
// FILL     | pre-fill SPR with the first strip
// SCAN     | one candidate resident per cycle, snake order
// DRAIN    | wait for the last SADs to reach the comparator
// DONE     | one-cycle done pulse
module me_scan_controller
  import me_pkg::*;
#(
  parameter  int MACRO_DIM  = 16,
  parameter  int SEARCH_DIM = 48,
  parameter  int SAD_LAT    = 2,
  localparam int RANGE      = me_range(MACRO_DIM, SEARCH_DIM),
  localparam int CW         = $clog2(MACRO_DIM),
  localparam int SW         = $clog2(SEARCH_DIM),
  localparam int MW         = $clog2(RANGE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          en_cpr_o,
  output logic          en_spr_o,
  output logic [1:0]    sel_o,
  output logic          valid_o,
  output logic [CW-1:0] cpr_rd_y_o,
  output logic [SW-1:0] spr_rd_x_o,
  output logic [SW-1:0] spr_rd_y_o,
  output logic [MW-1:0] mv_x_o,
  output logic [MW-1:0] mv_y_o
`ifdef ME_ABORT_EN
  ,
  input  logic          abort_i
`endif
);

  localparam logic [CW-1:0] CNT_LAST   = CW'(MACRO_DIM - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(SAD_LAT - 1);
  localparam logic [MW-1:0] POS_LAST   = MW'(RANGE - 1);
  localparam int            DW         = 1 + 2 * MW;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] x_q, x_d;
  logic [MW-1:0] y_q, y_d;
  logic          col_end;
  logic          cand_valid;
  logic          abort;
  sel_t          sel;
  logic [DW-1:0] dly_d, dly_q;

`ifdef ME_ABORT_EN
  assign abort = abort_i && (state_q != IDLE);
`else
  assign abort = 1'b0;
`endif

  // Odd columns run upward, so their end is at row 0.
  assign col_end = x_q[0] ? (y_q == '0) : (y_q == POS_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD_CPR;
          cnt_d   = '0;
        end
      end
      LOAD_CPR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN: begin
        if (col_end) begin
          if (x_q == POS_LAST) state_d = DRAIN;
          else                 x_d     = x_q + MW'(1);
        end else if (!x_q[0]) begin
          y_d = y_q + MW'(1);
        end else begin
          y_d = y_q - MW'(1);
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DRAIN_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    en_cpr_o   = 1'b0;
    en_spr_o   = 1'b0;
    sel        = SEL_DOWN;
    cand_valid = 1'b0;
    cpr_rd_y_o = '0;
    spr_rd_x_o = '0;
    spr_rd_y_o = '0;
    case (state_q)
      LOAD_CPR: begin
        en_cpr_o   = 1'b1;
        cpr_rd_y_o = cnt_q;
      end
      FILL: begin
        en_spr_o   = 1'b1;
        spr_rd_y_o = SW'(cnt_q);
      end
      SCAN: begin
        cand_valid = 1'b1;
        spr_rd_x_o = SW'(x_q);
        spr_rd_y_o = SW'(y_q);
        if (col_end) begin
          if (x_q != POS_LAST) begin
            en_spr_o   = 1'b1;
            sel        = SEL_LEFT;
            spr_rd_x_o = SW'(x_q) + SW'(1);
          end
        end else if (!x_q[0]) begin
          en_spr_o   = 1'b1;
          spr_rd_y_o = SW'(y_q) + SW'(MACRO_DIM);
        end else begin
          en_spr_o   = 1'b1;
          sel        = SEL_UP;
          spr_rd_y_o = SW'(y_q) - SW'(1);
        end
      end
      default: ;
    endcase
    if (abort) begin
      en_cpr_o = 1'b0;
      en_spr_o = 1'b0;
    end
  end

  assign sel_o = sel;
  assign dly_d = cand_valid ? {1'b1, x_q, y_q} : '0;

  me_delay_line #(
    .DEPTH(SAD_LAT),
    .WIDTH(DW)
  ) u_tag_dly (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(abort),
    .d_i  (dly_d),
    .q_o  (dly_q)
  );

  assign valid_o = dly_q[DW-1] && !abort;
  assign mv_x_o  = dly_q[2*MW-1:MW];
  assign mv_y_o  = dly_q[MW-1:0];

endmodule

// File: tb/tb_me_scan_controller.sv
// Self-checking bench for me_scan_controller: landmark table, cycle model, reset/abort sequences.
module tb_me_scan_controller;
  import me_pkg::*;

  localparam int M     = 16;
  localparam int S     = 48;
  localparam int L     = 2;
  localparam int R     = S - M + 1;
  localparam int TOTAL = 2 * M + R * R + L + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, en_cpr, en_spr, valid;
  logic [1:0] sel;
  logic [3:0] cpr_rd_y;
  logic [5:0] spr_rd_x, spr_rd_y, mv_x, mv_y;

  me_scan_controller #(.MACRO_DIM(M), .SEARCH_DIM(S), .SAD_LAT(L)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .en_cpr_o(en_cpr), .en_spr_o(en_spr), .sel_o(sel), .valid_o(valid),
    .cpr_rd_y_o(cpr_rd_y), .spr_rd_x_o(spr_rd_x), .spr_rd_y_o(spr_rd_y),
    .mv_x_o(mv_x), .mv_y_o(mv_y)
`ifdef ME_ABORT_EN
    , .abort_i(abort)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy, done, en_cpr, en_spr, sel, valid, cpr, rdx, rdy, mvx, mvy;
  } obs_t;

  typedef struct {
    int n;
    int en_cpr, cpr, en_spr, sel, valid, mvx, mvy, done, busy;
  } vec_t;

  int   n_checks = 0;
  int   n_fails  = 0;
  obs_t log_q [0:TOTAL+4];
  int   mb  [M][S];
  int   win [S][S];
  int   ref_min;

  task automatic check(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic obs_t sample();
    obs_t s;
    s.busy = busy;     s.done = done;     s.en_cpr = en_cpr; s.en_spr = en_spr;
    s.sel  = sel;      s.valid = valid;   s.cpr = cpr_rd_y;  s.rdx = spr_rd_x;
    s.rdy  = spr_rd_y; s.mvx = mv_x;      s.mvy = mv_y;
    return s;
  endfunction

  // Snake order: column x = k/R, even columns top-down, odd columns bottom-up.
  function automatic void snake(input int k, output int x, output int y);
    x = k / R;
    y = (x % 2 == 0) ? (k % R) : (R - 1 - k % R);
  endfunction

  // Expected outputs for cycle n after the start-accept cycle (n = 0).
  function automatic obs_t model(input int n);
    obs_t e = '{default: 0};
    int k, x, y;
    e.busy = (n >= 1 && n <= TOTAL);
    e.done = (n == TOTAL);
    if (n >= 1 && n <= M) begin
      e.en_cpr = 1; e.cpr = n - 1;
    end else if (n > M && n <= 2 * M) begin
      e.en_spr = 1; e.sel = SEL_DOWN; e.rdx = 0; e.rdy = n - M - 1;
    end else if (n > 2 * M && n <= 2 * M + R * R) begin
      k = n - 2 * M - 1;
      snake(k, x, y);
      if (k % R != R - 1) begin
        e.en_spr = 1; e.rdx = x;
        if (x % 2 == 0) begin e.sel = SEL_DOWN; e.rdy = y + M; end
        else            begin e.sel = SEL_UP;   e.rdy = y - 1; end
      end else if (x < R - 1) begin
        e.en_spr = 1; e.sel = SEL_LEFT; e.rdx = x + 1; e.rdy = y;
      end
    end
    k = n - 2 * M - 1 - L;
    if (k >= 0 && k < R * R) begin
      e.valid = 1;
      snake(k, e.mvx, e.mvy);
    end
    return e;
  endfunction

  task automatic check_cycle(input int n, input obs_t a);
    obs_t e = model(n);
    bit bad;
    bad = a.busy != e.busy || a.done != e.done || a.en_cpr != e.en_cpr ||
          a.en_spr != e.en_spr || a.valid != e.valid;
    if (e.en_cpr) bad |= a.cpr != e.cpr;
    if (e.en_spr) bad |= a.sel != e.sel || a.rdx != e.rdx || a.rdy != e.rdy;
    if (e.valid)  bad |= a.mvx != e.mvx || a.mvy != e.mvy;
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("FAIL cycle_%0d: got busy%0d done%0d cpr%0d/%0d spr%0d sel%0d rd(%0d,%0d) v%0d mv(%0d,%0d) expected busy%0d done%0d cpr%0d/%0d spr%0d sel%0d rd(%0d,%0d) v%0d mv(%0d,%0d)",
               n, a.busy, a.done, a.en_cpr, a.cpr, a.en_spr, a.sel, a.rdx, a.rdy, a.valid, a.mvx, a.mvy,
               e.busy, e.done, e.en_cpr, e.cpr, e.en_spr, e.sel, e.rdx, e.rdy, e.valid, e.mvx, e.mvy);
    end
  endtask

  function automatic int sad(input int cx, input int cy);
    int acc = 0;
    for (int j = 0; j < M; j++)
      for (int i = 0; i < M; i++)
        acc += (mb[j][i] > win[cy+j][cx+i]) ? mb[j][i] - win[cy+j][cx+i] : win[cy+j][cx+i] - mb[j][i];
    return acc;
  endfunction

  function automatic longint all_outputs();
    return {busy, done, en_cpr, en_spr, sel, valid, cpr_rd_y, spr_rd_x, spr_rd_y, mv_x, mv_y};
  endfunction

  task automatic run_search(input bit noise, input bit log_it, input bit golden);
    int  valid_cnt = 0, left_cnt = 0, done_at = -1, uniq = 0, min_sad = 1 << 30;
    bit  seen [R][R];
    obs_t s;
    for (int i = 0; i < R; i++) for (int j = 0; j < R; j++) seen[i][j] = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      check("idle_before_start", all_outputs(), 0);
    end
    start = 1'b1;
    for (int n = 1; n <= TOTAL + 3; n++) begin
      @(negedge clk);
      start = (noise && n <= TOTAL) ? 1'($urandom_range(0, 1)) : 1'b0;
      s = sample();
      if (log_it) log_q[n] = s;
      check_cycle(n, s);
      if (s.valid != 0) begin
        valid_cnt++;
        if (s.mvx < R && s.mvy < R && !seen[s.mvx][s.mvy]) begin
          seen[s.mvx][s.mvy] = 1'b1;
          uniq++;
        end
        if (golden && s.mvx < R && s.mvy < R && sad(s.mvx, s.mvy) < min_sad) min_sad = sad(s.mvx, s.mvy);
      end
      if (s.en_spr != 0 && s.sel == SEL_LEFT) left_cnt++;
      if (s.done != 0 && done_at < 0) done_at = n;
    end
    check("valid_pulses", valid_cnt, R * R);
    check("left_cycles", left_cnt, R - 1);
    check("done_cycle", done_at, TOTAL);
    check("unique_candidates", uniq, R * R);
    if (golden) check("min_sad", min_sad, ref_min);
  endtask

  initial begin
    vec_t tbl [13];
    obs_t a;
    tbl[0]  = '{n: 1,    en_cpr: 1, cpr: 0,  en_spr: 0, sel: 0, valid: 0, mvx: 0,  mvy: 0,  done: 0, busy: 1};
    tbl[1]  = '{n: 16,   en_cpr: 1, cpr: 15, en_spr: 0, sel: 0, valid: 0, mvx: 0,  mvy: 0,  done: 0, busy: 1};
    tbl[2]  = '{n: 17,   en_cpr: 0, cpr: 0,  en_spr: 1, sel: 0, valid: 0, mvx: 0,  mvy: 0,  done: 0, busy: 1};
    tbl[3]  = '{n: 32,   en_cpr: 0, cpr: 0,  en_spr: 1, sel: 0, valid: 0, mvx: 0,  mvy: 0,  done: 0, busy: 1};
    tbl[4]  = '{n: 35,   en_cpr: 0, cpr: 0,  en_spr: 1, sel: 0, valid: 1, mvx: 0,  mvy: 0,  done: 0, busy: 1};
    tbl[5]  = '{n: 65,   en_cpr: 0, cpr: 0,  en_spr: 1, sel: 2, valid: 1, mvx: 0,  mvy: 30, done: 0, busy: 1};
    tbl[6]  = '{n: 67,   en_cpr: 0, cpr: 0,  en_spr: 1, sel: 1, valid: 1, mvx: 0,  mvy: 32, done: 0, busy: 1};
    tbl[7]  = '{n: 68,   en_cpr: 0, cpr: 0,  en_spr: 1, sel: 1, valid: 1, mvx: 1,  mvy: 32, done: 0, busy: 1};
    tbl[8]  = '{n: 100,  en_cpr: 0, cpr: 0,  en_spr: 1, sel: 0, valid: 1, mvx: 1,  mvy: 0,  done: 0, busy: 1};
    tbl[9]  = '{n: 1121, en_cpr: 0, cpr: 0,  en_spr: 0, sel: 0, valid: 1, mvx: 32, mvy: 30, done: 0, busy: 1};
    tbl[10] = '{n: 1123, en_cpr: 0, cpr: 0,  en_spr: 0, sel: 0, valid: 1, mvx: 32, mvy: 32, done: 0, busy: 1};
    tbl[11] = '{n: 1124, en_cpr: 0, cpr: 0,  en_spr: 0, sel: 0, valid: 0, mvx: 0,  mvy: 0,  done: 1, busy: 1};
    tbl[12] = '{n: 1125, en_cpr: 0, cpr: 0,  en_spr: 0, sel: 0, valid: 0, mvx: 0,  mvy: 0,  done: 0, busy: 0};

    for (int j = 0; j < M; j++) for (int i = 0; i < M; i++) mb[j][i] = $urandom_range(0, 255);
    for (int j = 0; j < S; j++) for (int i = 0; i < S; i++) win[j][i] = $urandom_range(0, 255);
    ref_min = 1 << 30;
    for (int cy = 0; cy < R; cy++)
      for (int cx = 0; cx < R; cx++)
        if (sad(cx, cy) < ref_min) ref_min = sad(cx, cy);

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;

    run_search(1'b0, 1'b1, 1'b1);
    foreach (tbl[t]) begin
      a = log_q[tbl[t].n];
      check($sformatf("tbl%0d_busy", tbl[t].n), a.busy, tbl[t].busy);
      check($sformatf("tbl%0d_done", tbl[t].n), a.done, tbl[t].done);
      check($sformatf("tbl%0d_en_cpr", tbl[t].n), a.en_cpr, tbl[t].en_cpr);
      check($sformatf("tbl%0d_en_spr", tbl[t].n), a.en_spr, tbl[t].en_spr);
      check($sformatf("tbl%0d_valid", tbl[t].n), a.valid, tbl[t].valid);
      if (tbl[t].en_cpr != 0) check($sformatf("tbl%0d_cpr_rd_y", tbl[t].n), a.cpr, tbl[t].cpr);
      if (tbl[t].en_spr != 0) check($sformatf("tbl%0d_sel", tbl[t].n), a.sel, tbl[t].sel);
      if (tbl[t].valid != 0) begin
        check($sformatf("tbl%0d_mv_x", tbl[t].n), a.mvx, tbl[t].mvx);
        check($sformatf("tbl%0d_mv_y", tbl[t].n), a.mvy, tbl[t].mvy);
      end
    end

    // Random start activity throughout a run, including the DONE cycle, must be ignored.
    run_search(1'b1, 1'b0, 1'b0);

    // Synchronous reset while scanning column 5.
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 198; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_scan_outputs", all_outputs(), 0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("post_reset_quiet", all_outputs(), 0);
    end
    run_search(1'b0, 1'b0, 1'b0);

`ifdef ME_ABORT_EN
    // Abort while candidate (3,10) is resident.
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 154; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    #1;
    check("abort_en_spr_forced", en_spr, 0);
    check("abort_valid_forced", valid, 0);
    @(negedge clk);
    abort = 1'b0;
    for (int n = 0; n < TOTAL; n++) begin
      check("post_abort_quiet", all_outputs(), 0);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_idle_ignored", all_outputs(), 0);
    run_search(1'b0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
